// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and writeback.
// The stage itself connects through the slave modport.
interface alu_result_stage_if #(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              in_vout;
    logic              in_cout;
    logic [4:0]        in_code;
    logic [DEST_W-1:0] in_dest;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [DEST_W-1:0] out_dest;
    logic              out_z;
    logic              out_n;
    logic              out_v;
    logic              out_c;

    modport master (
        output in_valid, in_data, in_vout, in_cout,
        output in_code, in_dest, out_ready,
        input  in_ready, out_valid, out_data, out_dest,
        input  out_z, out_n, out_v, out_c
    );

    modport slave (
        input  in_valid, in_data, in_vout, in_cout,
        input  in_code, in_dest, out_ready,
        output in_ready, out_valid, out_data, out_dest,
        output out_z, out_n, out_v, out_c
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result FIFO with derived Z/N/V/C flags toward writeback.
// Optional sticky overflow/carry status enabled by STICKY_FLAGS_EN.
module alu_result_stage #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 2,
    parameter int DEST_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_stage_if.slave   bus,
    input  logic                flag_clr,
    output logic                status_v,
    output logic                status_c
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [DEST_W-1:0] dest;
        logic              z;
        logic              n;
        logic              v;
        logic              c;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_entry;
    entry_t          head;
    entry_t          head_n;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_ptr_n;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic            out_valid;
    logic            full;
    logic            push;
    logic            pop;
    logic            arith;

    assign full         = (count == CW'(DEPTH));
    assign bus.in_ready = !full && !rst;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = out_valid && bus.out_ready;
    assign arith        = (bus.in_code[4:3] == 2'b00);

    always_comb begin
        in_entry      = '0;
        in_entry.data = bus.in_data;
        in_entry.dest = bus.in_dest;
        in_entry.z    = (bus.in_data == '0);
        in_entry.n    = bus.in_data[WIDTH-1];
        in_entry.v    = arith && bus.in_vout;
        in_entry.c    = arith && bus.in_cout;
    end

    always_comb begin
        count_n  = count;
        rd_ptr_n = rd_ptr;
        unique case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
        if (pop) rd_ptr_n = rd_ptr + PW'(1);
        // Output registers preload the next head; a fresh push
        // lands at the head only when nothing else remains queued.
        head_n = head;
        if (count_n != '0) begin
            if (push && (wr_ptr == rd_ptr_n))
                head_n = in_entry;
            else
                head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            head      <= '0;
        end else begin
            count     <= count_n;
            rd_ptr    <= rd_ptr_n;
            out_valid <= (count_n != '0);
            head      <= head_n;
            if (push) wr_ptr <= wr_ptr + PW'(1);
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = head.data;
    assign bus.out_dest  = head.dest;
    assign bus.out_z     = head.z;
    assign bus.out_n     = head.n;
    assign bus.out_v     = head.v;
    assign bus.out_c     = head.c;

`ifdef STICKY_FLAGS_EN
    logic unused_ok;
    assign unused_ok = ^bus.in_code[2:0];

    // A clear coinciding with a flagged push keeps the new flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_v <= 1'b0;
            status_c <= 1'b0;
        end else if (flag_clr) begin
            status_v <= push && in_entry.v;
            status_c <= push && in_entry.c;
        end else if (push) begin
            status_v <= status_v | in_entry.v;
            status_c <= status_c | in_entry.c;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{bus.in_code[2:0], flag_clr};
    assign status_v  = 1'b0;
    assign status_c  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (DEPTH=2).
// Sticky-status vectors run only when STICKY_FLAGS_EN is defined.
module tb_alu_result_stage;
    logic clk;
    logic rst;
    logic flag_clr;
    logic status_v;
    logic status_c;
    int   n_checks;
    int   n_fail;

    alu_result_stage_if #(.WIDTH(16), .DEST_W(3)) bus ();

    alu_result_stage #(.WIDTH(16), .DEPTH(2), .DEST_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flag_clr (flag_clr),
        .status_v (status_v),
        .status_c (status_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [4:0] code,
                        input logic v, input logic c,
                        input logic [2:0] dest);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_code  = code;
        bus.in_vout  = v;
        bus.in_cout  = c;
        bus.in_dest  = dest;
        tick();
        bus.in_valid = 1'b0;
        bus.in_vout  = 1'b0;
        bus.in_cout  = 1'b0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        flag_clr      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_vout   = 1'b0;
        bus.in_cout   = 1'b0;
        bus.in_code   = '0;
        bus.in_dest   = '0;
        bus.out_ready = 1'b0;

        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_dest", bus.out_dest, 0);
        check("rst_out_zn", {bus.out_z, bus.out_n}, 0);
        check("rst_out_vc", {bus.out_v, bus.out_c}, 0);
        check("rst_status", {status_v, status_c}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // single push of zero
        push(16'h0000, 5'b00_000, 1'b0, 1'b0, 3'd5);
        check("single_valid", bus.out_valid, 1);
        check("single_z", bus.out_z, 1);
        check("single_n", bus.out_n, 0);
        check("single_dest", bus.out_dest, 5);
        pop();
        check("single_pop_valid", bus.out_valid, 0);

        // flag qualification
        push(16'h8000, 5'b00_000, 1'b1, 1'b1, 3'd1);
        check("arith_nvc", {bus.out_n, bus.out_v, bus.out_c}, 3'b111);
        check("arith_z", bus.out_z, 0);
`ifndef STICKY_FLAGS_EN
        check("nosticky_status", {status_v, status_c}, 0);
`endif
        pop();
        push(16'h8000, 5'b01_000, 1'b1, 1'b1, 3'd1);
        check("logic_nvc", {bus.out_n, bus.out_v, bus.out_c}, 3'b100);
        pop();
        push(16'h0005, 5'b01_011, 1'b1, 1'b1, 3'd2);
        check("oor_code_vc", {bus.out_v, bus.out_c}, 0);
        check("oor_code_data", bus.out_data, 16'h0005);
        pop();

        // fill to full, third push dropped
        push(16'h0001, 5'b00_000, 1'b0, 1'b0, 3'd0);
        check("fill1_ready", bus.in_ready, 1);
        push(16'h0002, 5'b00_000, 1'b0, 1'b0, 3'd0);
        check("full_ready", bus.in_ready, 0);
        push(16'h0003, 5'b00_000, 1'b0, 1'b0, 3'd0);
        check("full_hold_data", bus.out_data, 16'h0001);
        bus.out_ready = 1'b1;
        tick();
        check("drain1_data", bus.out_data, 16'h0002);
        check("drain1_valid", bus.out_valid, 1);
        check("drain1_ready", bus.in_ready, 1);
        tick();
        check("drain2_valid", bus.out_valid, 0);
        check("drain2_hold", bus.out_data, 16'h0002);
        bus.out_ready = 1'b0;

        // streaming with wrap-around
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0010 + 16'(i);
            bus.in_code  = 5'b00_000;
            tick();
            check("stream_valid", bus.out_valid, 1);
            check("stream_data", bus.out_data, 16'h0010 + 16'(i));
            check("stream_ready", bus.in_ready, 1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_end_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;

`ifdef STICKY_FLAGS_EN
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("sticky_clr0", {status_v, status_c}, 0);
        push(16'h0007, 5'b00_000, 1'b1, 1'b0, 3'd0);
        check("sticky_set_v", {status_v, status_c}, 2'b10);
        pop();
        check("sticky_hold_v", {status_v, status_c}, 2'b10);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("sticky_clr", {status_v, status_c}, 0);
        flag_clr = 1'b1;
        push(16'h0009, 5'b00_001, 1'b0, 1'b1, 3'd0);
        flag_clr = 1'b0;
        check("sticky_clr_push", {status_v, status_c}, 2'b01);
        pop();
`endif

        // reset mid-stream
        push(16'h00AA, 5'b00_000, 1'b1, 1'b1, 3'd3);
        push(16'h00BB, 5'b00_000, 1'b0, 1'b0, 3'd4);
        check("pre_rst_full", bus.in_ready, 0);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_status", {status_v, status_c}, 0);
        check("mid_rst_ready", bus.in_ready, 0);
        rst = 1'b0;
        push(16'h1234, 5'b00_000, 1'b0, 1'b0, 3'd2);
        check("after_rst_data", bus.out_data, 16'h1234);
        check("after_rst_dest", bus.out_dest, 2);
        pop();
        check("after_rst_only", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the 16-bit ALU. Captures each ALU result (C, vout, cout) with its opcode and destination tag into a small FIFO, derives zero/negative flags, and presents results to writeback over a valid/ready handshake. It decouples the combinational ALU from writeback stalls and, optionally, keeps a sticky overflow/carry status register.

## Interface
Parameters:
- WIDTH, 16, result width; must match the ALU.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- DEST_W, 3, destination register tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result present this cycle.
- in_ready  out  1  stage can accept; equals !full, and 0 while rst is high.
- in_data  in  WIDTH  ALU result C (signed).
- in_vout  in  1  ALU overflow flag.
- in_cout  in  1  ALU carry-out flag.
- in_code  in  5  ALU alu_code that produced the result.
- in_dest  in  DEST_W  destination tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts the head entry.
- out_data  out  WIDTH  head result.
- out_dest  out  DEST_W  head tag.
- out_z  out  1  head result == 0.
- out_n  out  1  head result bit WIDTH-1.
- out_v  out  1  head overflow (qualified).
- out_c  out  1  head carry (qualified).
- flag_clr  in  1  clear sticky status (STICKY_FLAGS_EN only).
- status_v  out  1  sticky overflow.
- status_c  out  1  sticky carry.

## Operation
- Push: in_valid && in_ready stores {in_data, in_dest, z, n, v, c} at the write pointer.
- Pop: out_valid && out_ready advances the read pointer.
- Flag derivation at push: z = (in_data == 0); n = in_data[WIDTH-1]; v = in_vout and c = in_cout only when in_code[4:3] == 2'b00 (arithmetic group); otherwise v = c = 0 regardless of inputs.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; occupancy count 0..DEPTH kept separately.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full (count == DEPTH): in_ready = 0, and input is ignored even if in_valid is high. in_ready has no combinational path from out_ready, so a pop at full does not allow a same-cycle push.
- Empty: out_valid = 0; out_* hold the last popped values (not required to be 0), and a pop request is ignored.
- Out-of-range in_code (e.g. 5'b01_011) is stored like any logic result (v = c = 0).

## Timing
- Reset: count, pointers, out_valid, status_v and status_c = 0; out_data, out_dest, out_z, out_n, out_v and out_c = 0; in_ready = 0 during reset and 1 on the first cycle after.
- Latency: a push into an empty FIFO gives out_valid = 1 on the next cycle. There is no bypass, so minimum latency is 1 cycle.
- Throughput: 1 result per cycle while out_ready is held high.
- Data on out_* is stable while out_valid && !out_ready.
- Reset asserted mid-operation: all entries are discarded on that edge, and no pop is reported.

## Configuration
- Macro: STICKY_FLAGS_EN.
- Defined:
  - status_v and status_c OR-accumulate the qualified v and c of every pushed entry, updated on the push edge.
  - flag_clr = 1 clears both status bits on that edge.
  - If flag_clr and a push carrying v or c = 1 occur in the same cycle, the new flag wins: status = push value.
- Undefined: status_v and status_c are tied to 0, flag_clr is ignored, and no sticky registers are generated.

## Test plan
- Single push: after reset, push in_data=16'h0000, code=5'b00_000, vout=0 -> next cycle out_valid=1, out_z=1, out_n=0; pop -> out_valid=0.
- Flag qualification: push in_data=16'h8000, vout=1, cout=1, code=5'b00_000 -> out_n=1, out_v=1, out_c=1; same inputs with code=5'b01_000 -> out_v=0, out_c=0.
- Full/backpressure: out_ready=0; push 16'h0001 and then 16'h0002 with DEPTH=2 -> in_ready=0; a third push of 16'h0003 is dropped. Then raise out_ready -> pops return 1, 2 in order; in_ready returns to 1 the cycle after the first pop.
- Streaming with wrap-around: out_ready=1 and 10 consecutive pushes 16'h0010..16'h0019 -> 10 in-order pops, each one cycle after its push, and count never exceeds 1.
- Sticky flags (STICKY_FLAGS_EN): push with vout=1 (add) -> status_v=1 and stays 1 after pop. flag_clr alone -> 0. flag_clr together with a cout=1 push -> status_c=1.
- Reset mid-stream: with 2 entries held, assert rst for 1 cycle -> out_valid=0 and status = 0; the next push is delivered as the only entry.
